// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Single-clock FIFO controller with an internal memory array.
//               - Registered read port (one-cycle latency) with a valid strobe.
//               - Occupancy counter and status flags decoded from it.
//               - Overflow / underflow error indications.
//
// Ports       : clk          - single clock, rising edge
//               rst          - asynchronous active-high reset
//               wr_en        - write request
//               wr_data      - write word [DATA_W-1:0]
//               rd_en        - read request
//               err_clr      - clears sticky errors (FIFO_ERR_STICKY_EN only)
//               rd_data      - registered read word [DATA_W-1:0]
//               rd_valid     - rd_data holds a word popped on the previous edge
//               full, empty, almost_full, almost_empty - status flags
//               count        - occupancy 0..DEPTH [ADDR_W:0]
//               overflow     - write rejected because the FIFO was full
//               underflow    - read attempted while the FIFO was empty
//
// Build option: FIFO_ERR_STICKY_EN
//               defined   -> overflow/underflow are sticky until err_clr/rst
//               undefined -> overflow/underflow are one-cycle pulses
//
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
`ifdef FIFO_ERR_STICKY_EN
  input  logic                      err_clr,
`endif
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_af_level = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   c_ae_level = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_ptr_one  = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_ovf_evt;
  logic w_udf_evt;

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);

  // A write into a full FIFO is still accepted when a read frees a slot on
  // the same edge; a read from an empty FIFO is never accepted, even if a
  // write arrives on the same edge.
  assign w_wr_acc  = wr_en & (~w_full | rd_en);
  assign w_rd_acc  = rd_en & ~w_empty;
  assign w_ovf_evt = wr_en & w_full & ~rd_en;
  assign w_udf_evt = rd_en & w_empty;

  // Storage is deliberately left out of reset; the cleared pointers make any
  // stale contents unreachable.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !rst) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // When full with simultaneous read and write, rd_ptr equals wr_ptr; the
  // read samples the old word because the memory write lands at the same
  // edge through a non-blocking update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
`ifdef FIFO_ERR_STICKY_EN
      // A new event on the clearing edge keeps the flag set.
      r_overflow  <= w_ovf_evt | (r_overflow  & ~err_clr);
      r_underflow <= w_udf_evt | (r_underflow & ~err_clr);
`else
      r_overflow  <= w_ovf_evt;
      r_underflow <= w_udf_evt;
`endif
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= c_af_level);
  assign almost_empty = (r_count <= c_ae_level);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, >=4).
REQ-003 SHALL have parameter AF_LEVEL, default 14, occupancy at or above which almost_full asserts (1..DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 2, occupancy at or below which almost_empty asserts (0..DEPTH-1).
REQ-005 SHALL derive localparam ADDR_W = log2(DEPTH); it is not user-settable.
REQ-006 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wr_data  input  DATA_W  write word.
REQ-010 SHALL have port rd_en  input  1  read request.
REQ-011 SHALL have port rd_data  output  DATA_W  registered read word.
REQ-012 SHALL have port rd_valid  output  1  rd_data carries a word popped on the previous edge.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have ports overflow, underflow  output  1 each  error indications (see REQ-031..033).
REQ-016 SHALL have port err_clr  input  1  clears sticky errors; present only when FIFO_ERR_STICKY_EN is defined.

Function
REQ-017 SHALL accept a write when wr_en=1 and (full=0 or rd_en=1).
REQ-018 SHALL accept a read when rd_en=1 and empty=0.
REQ-019 SHALL store an accepted write at wr_ptr and advance wr_ptr by 1 modulo DEPTH.
REQ-020 SHALL load mem[rd_ptr] into rd_data on an accepted read, advance rd_ptr modulo DEPTH, and assert rd_valid for exactly the following cycle.
REQ-021 SHALL hold rd_data unchanged and drive rd_valid=0 in cycles following no accepted read.
REQ-022 SHALL give read latency of one cycle: word popped at edge N is on rd_data with rd_valid=1 during cycle N..N+1.
REQ-023 SHALL update count at the same edge as the accepted operation: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 SHALL drive full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL), all decoded from registered count.
REQ-025 SHALL, when full and wr_en=rd_en=1, accept both; rd_data returns the oldest word, the new word occupies the freed slot, count stays DEPTH.
REQ-026 SHALL, when empty and wr_en=rd_en=1, accept the write only; count becomes 1, rd_valid stays 0, underflow event raised.
REQ-027 SHALL wrap both pointers from DEPTH-1 to 0 with no loss or reordering; data order is strictly first-in first-out.
REQ-028 SHALL never alter memory or pointers on a rejected request.

Reset
REQ-029 SHALL, while rst=1, immediately clear wr_ptr, rd_ptr, count, rd_data (all zeros), rd_valid, overflow, underflow; outputs empty=1, almost_empty=1, full=0, almost_full=0.
REQ-030 SHALL not reset memory contents; reset mid-operation discards all stored words and any pending rd_valid.

Configuration
REQ-031 SHALL define overflow event = wr_en & full & ~rd_en, underflow event = rd_en & empty.
REQ-032 SHALL, with FIFO_ERR_STICKY_EN defined, register overflow/underflow as sticky flags set on the event edge and cleared only by err_clr=1 at an edge (set wins if simultaneous) or by reset; port err_clr exists.
REQ-033 SHALL, without FIFO_ERR_STICKY_EN, register overflow/underflow as one-cycle pulses high in the cycle after each event; err_clr port is absent.

Verification (DATA_W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-034 SHALL cover: reset, write 0x01..0x10 on 16 edges -> count=16, full=1, almost_full=1 from count 14; read 16 -> rd_data 0x01..0x10 in order, each rd_valid one cycle after rd_en, empty=1 at end.
REQ-035 SHALL cover: full FIFO, wr_en=rd_en=1 with wr_data=0xAA -> rd_data=0x01, count stays 16, 0xAA read out last.
REQ-036 SHALL cover: empty FIFO, wr_en=rd_en=1 with 0x55 -> count=1, rd_valid=0, underflow raised; next read returns 0x55.
REQ-037 SHALL cover: full FIFO, wr_en=1 rd_en=0 with 0xFF -> count=16, overflow raised, 0xFF never read; sticky build holds until err_clr, pulse build drops after one cycle.
REQ-038 SHALL cover: 40 interleaved writes/reads crossing pointer wrap twice -> output sequence equals input sequence, count matches model every cycle.
REQ-039 SHALL cover: rst asserted mid-cycle with count=9 and read in flight -> outputs clear asynchronously, rd_valid=0, empty=1, next write/read returns the new word.
